tcp_tx_arbiter: RTL and testbench
=================================

// Module: tcp_tx_arbiter
// PURPOSE
//  Packet-level round-robin arbiter: merges NUM_SRC AXIS64 TX sources (ARP, ICMP, UDP, TCP) onto one AXIS64 stream toward the MAC.
//  Grant locks for a whole packet (first beat to Last). Per-source enable and status via BUS16 local bus.
// PARAMETERS
//  NUM_SRC   4   number of source streams, 2..8
//  GRANT_W   $clog2(NUM_SRC)   grant index width (localparam)
// PORTS
//  Clk        in   1           single clock for all logic
//  Reset      in   1           asynchronous, active-high
//  InValid    in   NUM_SRC     per-source Valid
//  InReady    out  NUM_SRC     per-source Ready
//  InData     in   NUM_SRC*64  source i at [64*i+:64]
//  InKeep     in   NUM_SRC*8   source i at [8*i+:8]
//  InLast     in   NUM_SRC     per-source Last
//  Out        AXIS64.m  -      merged stream (Valid/Data/Keep/Last out, Ready in)
//  Bus        BUS16.s   -      config/status local bus
// BEHAVIOUR
//  Reset values: Out.Valid=0, InReady=0, Bus.Done=0, Bus.ReadData=0, grant=0, rr_ptr=0, EnableMask=all ones, state=IDLE.
//  FSM IDLE: eligible = InValid & EnableMask. If eligible!=0, pick the first set bit searching rr_ptr, rr_ptr+1, ... (mod NUM_SRC).
//   Register it as grant and go to XFER. No output activity in IDLE.
//  FSM XFER: Out.{Valid,Data,Keep,Last} = source[grant], combinational mux.
//   InReady[grant]=Out.Ready; every other InReady=0.
//   On Out.Valid & Out.Ready & Out.Last: rr_ptr<=grant+1 (wraps NUM_SRC-1 -> 0) and go to IDLE.
//  Latency: first beat appears 1 cycle after arbitration.
//   One idle bubble cycle between back-to-back packets; decided, not a bug.
//  Out.Valid=0 from a granted source mid-packet: grant holds, no timeout.
//  EnableMask change mid-packet: current packet completes. New mask applies at the next IDLE decision.
//  Single-beat packet (Valid+Last on first beat): XFER lasts one cycle if Out.Ready=1.
//  Asynchronous Reset mid-packet: immediate return to reset values. The packet is truncated; downstream must discard it.
//  Bus: WriteEnable[1] writes byte [15:8], WriteEnable[0] writes byte [7:0].
//   Bus.Done pulses 1 cycle, one cycle after any WriteEnable!=0 or ReadEnable.
//   ReadData is registered and valid with Done. Unmapped addresses read 0; writes to them are ignored.
//  Register map (byte addresses):
//   0x00 RW  EnableMask [NUM_SRC-1:0]; upper bits read 0.
//   0x02 RO  {Busy[15], 0, Grant[GRANT_W-1:0] in [2:0]}; Busy=(state==XFER).
//   0x04 RO  raw InValid [NUM_SRC-1:0].
// CONFIGURATION
//  TCP_TXARB_STATS_EN defined:
//   Per-source 16-bit packet counter, incremented on each accepted Last beat of that source. Wraps 0xFFFF->0.
//   Read at 0x10+2*i. Any write to 0x10+2*i clears counter i.
//   A write coincident with an increment: clear wins.
//  Not defined: counters absent; 0x10.. read 0; no extra flops.
// STRUCTURE
//  Package tcp_txarb_pkg: typedef enum logic {IDLE, XFER} txarb_state_t.
//   Also register address localparams: TXARB_ENABLE=16'h0000, TXARB_STATUS=16'h0002, TXARB_VALID=16'h0004, TXARB_STATS=16'h0010.
//  One sub-module: txarb_rr_pick (pure combinational). Inputs: eligible, rr_ptr. Outputs: found, idx.
//  The FSM, mux and bus decode stay in tcp_tx_arbiter.
// TESTING
//  1. All 4 sources hold 3-beat packets, Out.Ready=1:
//     grant order 0,1,2,3,0. Each packet is 3 beats with 1 idle cycle between packets.
//  2. Src2 packet running; src0 raises Valid mid-packet; random Out.Ready stalls:
//     src2 completes uninterrupted with data intact; src0 follows. No InReady[0] before then.
//  3. Write 0x00=0x0005 while src1 mid-packet:
//     src1 finishes; afterwards only src0/src2 are granted. Read 0x00 returns 0x0005.
//  4. Assert Reset on the 2nd beat of a src3 packet:
//     Out.Valid=0, all InReady=0 the same cycle. After release, grant starts from src0 (rr_ptr=0).
//  5. Bus read 0x02 during a src1 transfer:
//     Done 1 cycle after ReadEnable; ReadData=0x8001. Read 0x06 -> 0x0000.
//  6. With TCP_TXARB_STATS_EN: send 3 src1 packets -> read 0x12=0x0003.
//     Write 0x12 coincident with a Last beat -> reads 0.

Source files
------------

// File: rtl/tcp_tx_arbiter_pkg.sv
// Shared types and register map for the TCP/IP TX packet arbiter.
// Holds the arbiter FSM state encoding and the BUS16 register byte addresses.
package tcp_txarb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } txarb_state_t;

    localparam logic [15:0] TXARB_ENABLE = 16'h0000;
    localparam logic [15:0] TXARB_STATUS = 16'h0002;
    localparam logic [15:0] TXARB_VALID  = 16'h0004;
    localparam logic [15:0] TXARB_STATS  = 16'h0010;

endpackage

// File: rtl/tcp_tx_arbiter_if.sv
// AXIS64 stream and BUS16 local-bus interfaces used by the TX arbiter.
interface AXIS64;
    logic        Valid;
    logic [63:0] Data;
    logic [7:0]  Keep;
    logic        Last;
    logic        Ready;

    modport m (output Valid, Data, Keep, Last, input Ready);
    modport s (input Valid, Data, Keep, Last, output Ready);
endinterface

interface BUS16;
    logic [15:0] Address;
    logic [15:0] WriteData;
    logic [1:0]  WriteEnable;
    logic        ReadEnable;
    logic [15:0] ReadData;
    logic        Done;

    modport m (output Address, WriteData, WriteEnable, ReadEnable, input ReadData, Done);
    modport s (input Address, WriteData, WriteEnable, ReadEnable, output ReadData, Done);
endinterface

// File: rtl/tcp_tx_arbiter_rr_pick.sv
// Round-robin picker: first eligible source at or after rr_ptr, wrapping modulo NUM_SRC.
module txarb_rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int GRANT_W = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] eligible,
    input  logic [GRANT_W-1:0] rr_ptr,
    output logic               found,
    output logic [GRANT_W-1:0] idx
);
    logic [2*NUM_SRC-1:0] dbl;
    logic [NUM_SRC-1:0]   rot;
    logic [GRANT_W:0]     off;
    logic [GRANT_W:0]     sum;

    always_comb begin
        dbl   = {eligible, eligible} >> rr_ptr;
        rot   = dbl[NUM_SRC-1:0];
        found = 1'b0;
        off   = '0;
        // Descending scan so the smallest offset from rr_ptr wins.
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off   = (GRANT_W+1)'(k);
            end
        end
        sum = {1'b0, rr_ptr} + off;
        if (sum >= (GRANT_W+1)'(NUM_SRC))
            idx = GRANT_W'(sum - (GRANT_W+1)'(NUM_SRC));
        else
            idx = GRANT_W'(sum);
    end
endmodule

// File: rtl/tcp_tx_arbiter.sv
// Packet-level round-robin merge of NUM_SRC AXIS64 TX sources onto one MAC-bound stream.
// Optional TCP_TXARB_STATS_EN adds per-source 16-bit packet counters at 0x10+2*i.
module tcp_tx_arbiter
    import tcp_txarb_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [NUM_SRC-1:0]    InValid,
    output logic [NUM_SRC-1:0]    InReady,
    input  logic [NUM_SRC*64-1:0] InData,
    input  logic [NUM_SRC*8-1:0]  InKeep,
    input  logic [NUM_SRC-1:0]    InLast,
    AXIS64.m                      Out,
    BUS16.s                       Bus
);
    localparam int GRANT_W = $clog2(NUM_SRC);

    txarb_state_t       state, state_nxt;
    logic [GRANT_W-1:0] grant, grant_nxt, rr_ptr, rr_ptr_nxt, pick_idx, grant_inc;
    logic [NUM_SRC-1:0] enable_mask, eligible;
    logic               pick_found, beat_fire, last_fire, bus_wr;
    logic [15:0]        rd_mux;

    assign eligible  = InValid & enable_mask;
    assign grant_inc = (grant == GRANT_W'(NUM_SRC - 1)) ? '0 : grant + GRANT_W'(1);
    assign beat_fire = Out.Valid & Out.Ready;
    assign last_fire = beat_fire & Out.Last;
    assign bus_wr    = |Bus.WriteEnable;

    txarb_rr_pick #(.NUM_SRC(NUM_SRC), .GRANT_W(GRANT_W)) u_pick (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    // Output mux is combinational so the granted source sees Out.Ready directly.
    always_comb begin
        Out.Valid = 1'b0;
        Out.Data  = '0;
        Out.Keep  = '0;
        Out.Last  = 1'b0;
        InReady   = '0;
        if (state == XFER) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (grant == GRANT_W'(i)) begin
                    Out.Valid  = InValid[i];
                    Out.Data   = InData[64*i +: 64];
                    Out.Keep   = InKeep[8*i +: 8];
                    Out.Last   = InLast[i];
                    InReady[i] = Out.Ready;
                end
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        rr_ptr_nxt = rr_ptr;
        case (state)
            IDLE: if (pick_found) begin
                grant_nxt = pick_idx;
                state_nxt = XFER;
            end
            XFER: if (last_fire) begin
                rr_ptr_nxt = grant_inc;
                state_nxt  = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

`ifdef TCP_TXARB_STATS_EN
    logic [15:0] pkt_cnt [NUM_SRC];

    // A bus write to a counter takes priority over a same-cycle increment.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_SRC; i++) pkt_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (bus_wr && Bus.Address == TXARB_STATS + 16'(2*i))
                    pkt_cnt[i] <= '0;
                else if (last_fire && grant == GRANT_W'(i))
                    pkt_cnt[i] <= pkt_cnt[i] + 16'd1;
            end
        end
    end
`endif

    always_comb begin
        rd_mux = '0;
        case (Bus.Address)
            TXARB_ENABLE: rd_mux[NUM_SRC-1:0] = enable_mask;
            TXARB_STATUS: begin
                rd_mux[15]          = (state == XFER);
                rd_mux[GRANT_W-1:0] = grant;
            end
            TXARB_VALID:  rd_mux[NUM_SRC-1:0] = InValid;
            default:      rd_mux = '0;
        endcase
`ifdef TCP_TXARB_STATS_EN
        for (int i = 0; i < NUM_SRC; i++) begin
            if (Bus.Address == TXARB_STATS + 16'(2*i)) rd_mux = pkt_cnt[i];
        end
`endif
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            enable_mask  <= '1;
            Bus.Done     <= 1'b0;
            Bus.ReadData <= '0;
        end else begin
            Bus.Done     <= bus_wr | Bus.ReadEnable;
            Bus.ReadData <= Bus.ReadEnable ? rd_mux : 16'h0000;
            // The mask lives entirely in the low byte, since NUM_SRC is at most 8.
            if (Bus.WriteEnable[0] && Bus.Address == TXARB_ENABLE)
                enable_mask <= Bus.WriteData[NUM_SRC-1:0];
        end
    end
endmodule

// File: tb/tb_tcp_tx_arbiter.sv
// Scoreboard bench for tcp_tx_arbiter: per-source expected beat queues plus an expected grant order.
module tb_tcp_tx_arbiter;
    import tcp_txarb_pkg::*;

    localparam int NUM_SRC = 4;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    logic                  clk;
    logic                  rst;
    logic [NUM_SRC-1:0]    in_valid;
    logic [NUM_SRC-1:0]    in_ready;
    logic [NUM_SRC-1:0]    in_last;
    logic [NUM_SRC*64-1:0] in_data;
    logic [NUM_SRC*8-1:0]  in_keep;

    AXIS64 out_if();
    BUS16  bus_if();

    tcp_tx_arbiter #(.NUM_SRC(NUM_SRC)) dut (
        .Clk     (clk),
        .Reset   (rst),
        .InValid (in_valid),
        .InReady (in_ready),
        .InData  (in_data),
        .InKeep  (in_keep),
        .InLast  (in_last),
        .Out     (out_if),
        .Bus     (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int    n_chk = 0;
    int    n_fail = 0;
    beat_t src_q [NUM_SRC][$];
    beat_t exp_q [NUM_SRC][$];
    int    grant_q [$];
    int    cyc = 0, last_cyc = 0, cur_src = 0, ready_mode = 0, pkt_id = 0;
    bit    in_pkt = 0, have_last = 0, gap_chk = 0;
    logic [15:0] bus_addr_n = '0, bus_wdata_n = '0;
    logic [1:0]  bus_we_n = '0;
    logic        bus_re_n = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic int pending();
        int p;
        p = grant_q.size() + int'(in_pkt);
        for (int i = 0; i < NUM_SRC; i++) p += exp_q[i].size();
        return p;
    endfunction

    task automatic load_pkt(input int s, input int nb, input bit expd);
        beat_t b;
        pkt_id++;
        for (int j = 0; j < nb; j++) begin
            b.d = {8'(s), 8'(pkt_id), 16'(j), 32'($urandom)};
            b.k = (j == nb - 1) ? 8'($urandom_range(1, 255)) : 8'hFF;
            b.l = (j == nb - 1);
            src_q[s].push_back(b);
            if (expd) exp_q[s].push_back(b);
        end
    endtask

    // One clock: drive at the falling edge, settle, then score what the next rising edge will take.
    task automatic step();
        int s;
        beat_t e;
        logic [NUM_SRC-1:0] exp_rdy;
        @(negedge clk);
        cyc++;
        case (ready_mode)
            0:       out_if.Ready = 1'b1;
            1:       out_if.Ready = 1'($urandom_range(0, 1));
            default: out_if.Ready = 1'b0;
        endcase
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_q[i].size() > 0) begin
                in_valid[i]        = 1'b1;
                in_data[64*i +: 64] = src_q[i][0].d;
                in_keep[8*i +: 8]  = src_q[i][0].k;
                in_last[i]         = src_q[i][0].l;
            end else begin
                in_valid[i] = 1'b0;
                in_last[i]  = 1'b0;
            end
        end
        bus_if.Address     = bus_addr_n;
        bus_if.WriteData   = bus_wdata_n;
        bus_if.WriteEnable = bus_we_n;
        bus_if.ReadEnable  = bus_re_n;
        #1;
        s = int'(out_if.Data[63:56]);
        if (out_if.Valid) begin
            exp_rdy = '0;
            if (s < NUM_SRC && out_if.Ready) exp_rdy[s] = 1'b1;
            check_val("in_ready", 64'(in_ready), 64'(exp_rdy));
        end else if (!in_pkt) begin
            check_val("idle_ready", 64'(in_ready), 64'(0));
        end
        if (out_if.Valid && out_if.Ready) begin
            if (s >= NUM_SRC || exp_q[s].size() == 0) begin
                check_val("unexpected_beat", out_if.Data, 64'(0));
            end else begin
                e = exp_q[s].pop_front();
                check_val("data", out_if.Data, e.d);
                check_val("keep", 64'(out_if.Keep), 64'(e.k));
                check_val("last", 64'(out_if.Last), 64'(e.l));
                if (!in_pkt) begin
                    if (grant_q.size() == 0) check_val("grant_unexpected", 64'(s), 64'(NUM_SRC));
                    else check_val("grant_order", 64'(s), 64'(grant_q.pop_front()));
                    if (gap_chk && have_last) check_val("bubble", 64'(cyc - last_cyc), 64'(2));
                    in_pkt  = 1'b1;
                    cur_src = s;
                end else begin
                    check_val("src_hold", 64'(s), 64'(cur_src));
                end
                if (out_if.Last) begin
                    in_pkt    = 1'b0;
                    last_cyc  = cyc;
                    have_last = 1'b1;
                end
            end
        end
        for (int i = 0; i < NUM_SRC; i++)
            if (in_valid[i] && in_ready[i]) void'(src_q[i].pop_front());
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (pending() != 0 && n < budget) begin
            step();
            n++;
        end
        check_val("drain_pending", 64'(pending()), 64'(0));
    endtask

    task automatic wait_pkt(input int s, input int budget);
        int n;
        n = 0;
        while (!(in_pkt && cur_src == s) && n < budget) begin
            step();
            n++;
        end
        check_val("wait_pkt", 64'(in_pkt && cur_src == s), 64'(1));
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        bus_addr_n  = a;
        bus_wdata_n = d;
        bus_we_n    = 2'b11;
        step();
        bus_we_n = 2'b00;
        step();
        check_val("wr_done", 64'(bus_if.Done), 64'(1));
        step();
        check_val("wr_done_pulse", 64'(bus_if.Done), 64'(0));
    endtask

    task automatic bus_read(input logic [15:0] a, input logic [15:0] expv, input string tag);
        bus_addr_n = a;
        bus_re_n   = 1'b1;
        step();
        bus_re_n = 1'b0;
        step();
        check_val("rd_done", 64'(bus_if.Done), 64'(1));
        check_val(tag, 64'(bus_if.ReadData), 64'(expv));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = '0; in_last = '0; in_data = '0; in_keep = '0;
        out_if.Ready = 1'b0;
        bus_if.Address = '0; bus_if.WriteData = '0; bus_if.WriteEnable = '0; bus_if.ReadEnable = 1'b0;
        step();
        step();
        check_val("rst_valid", 64'(out_if.Valid), 64'(0));
        check_val("rst_ready", 64'(in_ready), 64'(0));
        check_val("rst_done", 64'(bus_if.Done), 64'(0));
        check_val("rst_rdata", 64'(bus_if.ReadData), 64'(0));
        rst = 1'b0;
        bus_read(TXARB_ENABLE, 16'h000F, "rst_mask");
        bus_read(TXARB_STATUS, 16'h0000, "rst_status");

        // Four sources, 3-beat packets, full throughput.
        ready_mode = 0;
        gap_chk = 1'b1; have_last = 1'b0;
        load_pkt(0, 3, 1); load_pkt(0, 3, 1);
        load_pkt(1, 3, 1); load_pkt(2, 3, 1); load_pkt(3, 3, 1);
        grant_q = '{0, 1, 2, 3, 0};
        step();
        step();
        check_val("first_latency", 64'(out_if.Valid), 64'(1));
        drain(100);
        gap_chk = 1'b0;

        // src2 running under random backpressure while src0 arrives.
        ready_mode = 1;
        load_pkt(2, 5, 1);
        grant_q.push_back(2);
        wait_pkt(2, 20);
        step();
        load_pkt(0, 3, 1);
        grant_q.push_back(0);
        drain(200);

        // Mask change mid-packet on src1.
        ready_mode = 0;
        load_pkt(1, 6, 1);
        grant_q.push_back(1);
        step();
        step();
        bus_write(TXARB_ENABLE, 16'h0005);
        load_pkt(0, 3, 1); load_pkt(2, 3, 1);
        load_pkt(1, 3, 0); load_pkt(3, 3, 0);
        grant_q.push_back(2); grant_q.push_back(0);
        drain(60);
        repeat (6) step();
        bus_read(TXARB_VALID, 16'h000A, "raw_valid");
        src_q[1].delete();
        src_q[3].delete();
        step();
        bus_read(TXARB_ENABLE, 16'h0005, "mask_rb");
        bus_write(TXARB_ENABLE, 16'h000F);

        // Asynchronous reset during the second beat of a src3 packet.
        load_pkt(3, 3, 1);
        grant_q.push_back(3);
        wait_pkt(3, 20);
        step();
        rst = 1'b1;
        #1;
        check_val("rst_mid_valid", 64'(out_if.Valid), 64'(0));
        check_val("rst_mid_ready", 64'(in_ready), 64'(0));
        for (int i = 0; i < NUM_SRC; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        grant_q.delete();
        in_pkt = 1'b0;
        in_valid = '0;
        step();
        step();
        rst = 1'b0;
        load_pkt(0, 2, 1); load_pkt(1, 2, 1); load_pkt(2, 2, 1); load_pkt(3, 2, 1);
        grant_q = '{0, 1, 2, 3};
        drain(60);

        // Status read while src1 is transferring.
        load_pkt(1, 4, 1);
        grant_q.push_back(1);
        wait_pkt(1, 20);
        bus_read(TXARB_STATUS, 16'h8001, "status_busy");
        bus_read(16'h0006, 16'h0000, "unmapped");
        drain(40);

`ifdef TCP_TXARB_STATS_EN
        bus_write(TXARB_STATS + 16'h0002, 16'h0000);
        for (int p = 0; p < 3; p++) begin
            load_pkt(1, 2, 1);
            grant_q.push_back(1);
        end
        drain(60);
        bus_read(TXARB_STATS + 16'h0002, 16'h0003, "stats_count");
        ready_mode = 2;
        load_pkt(1, 1, 1);
        grant_q.push_back(1);
        begin
            int n;
            n = 0;
            while (!out_if.Valid && n < 20) begin
                step();
                n++;
            end
        end
        check_val("stall_valid", 64'(out_if.Valid), 64'(1));
        ready_mode = 0;
        bus_write(TXARB_STATS + 16'h0002, 16'h0000);
        drain(20);
        bus_read(TXARB_STATS + 16'h0002, 16'h0000, "stats_clear_wins");
`else
        bus_read(TXARB_STATS, 16'h0000, "stats_absent0");
        bus_read(TXARB_STATS + 16'h0002, 16'h0000, "stats_absent1");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
